// File: rtl/mem_access_unit_if.sv
// Core-side request/response and RAM-side signals of mem_access_unit.
// slave  : the access unit itself.
// master : whoever drives requests and models the RAM (core + RAM, or a bench).
interface mem_access_unit_if #(
    parameter int ADDR_W = 10
);
    // core side
    logic              req;
    logic              we;
    logic [2:0]        funct3;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ready;
    logic              busy;
    logic              err;
    // RAM side
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_rden;
    logic              mem_wren;
    logic [31:0]       mem_q;

    modport slave (
        input  req, we, funct3, addr, wdata, mem_q,
        output rdata, ready, busy, err,
               mem_addr, mem_wdata, mem_be, mem_rden, mem_wren
    );

    modport master (
        output req, we, funct3, addr, wdata, mem_q,
        input  rdata, ready, busy, err,
               mem_addr, mem_wdata, mem_be, mem_rden, mem_wren
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: turns RV32I byte/half/word loads and stores into word-wide
// RAM accesses with byte enables, extends load data and pulses ready on done.
// RAM read latency RD_LAT (1..3) is absorbed by a down-counter in RD_WAIT.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses raise err
// and touch no RAM; without it the low address bits are forced to alignment.
// All outputs are flops; next values come from the single always_comb below.
module mem_access_unit #(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input logic              clk,
    input logic              rst_n,
    mem_access_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_CAP, WR, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lo_q, lo_d;          // aligned byte offset within word
    logic [1:0]        cnt_q, cnt_d;        // remaining RD_WAIT cycles
    logic [31:0]       rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic              mem_rden_q, mem_rden_d;
    logic              mem_wren_q, mem_wren_d;

    logic [1:0]        sz;
    logic              legal;
    logic [ADDR_W+1:0] a_al;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;

    // Byte address bits above the RAM window are ignored (address wraps).
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        f3_d        = f3_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        ready_d     = 1'b0;
        err_d       = 1'b0;
        mem_rden_d  = 1'b0;
        mem_wren_d  = 1'b0;

        sz    = bus.funct3[1:0];
        legal = bus.we ? (bus.funct3 inside {3'b000, 3'b001, 3'b010})
                       : (bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef MISALIGN_TRAP_EN
        if ((sz == 2'b01 && bus.addr[0]) || (sz == 2'b10 && bus.addr[1:0] != 2'b00))
            legal = 1'b0;
`endif
        // With the trap enabled a misaligned access never uses a_al, so the
        // forced alignment is harmless in both builds.
        a_al = bus.addr[ADDR_W+1:0];
        if (sz == 2'b01) a_al[0]   = 1'b0;
        if (sz == 2'b10) a_al[1:0] = 2'b00;

        lane_b = bus.mem_q[{lo_q, 3'b000} +: 8];
        lane_h = lo_q[1] ? bus.mem_q[31:16] : bus.mem_q[15:0];

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    f3_d = bus.funct3;
                    lo_d = a_al[1:0];
                    if (!legal) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        mem_addr_d = a_al[ADDR_W+1:2];
                        if (bus.we) begin
                            state_d    = WR;
                            mem_wren_d = 1'b1;
                            case (sz)
                                2'b00: begin
                                    mem_be_d    = 4'b0001 << a_al[1:0];
                                    mem_wdata_d = {4{bus.wdata[7:0]}};
                                end
                                2'b01: begin
                                    mem_be_d    = a_al[1] ? 4'b1100 : 4'b0011;
                                    mem_wdata_d = {2{bus.wdata[15:0]}};
                                end
                                default: begin
                                    mem_be_d    = 4'b1111;
                                    mem_wdata_d = bus.wdata;
                                end
                            endcase
                        end else begin
                            state_d    = RD_WAIT;
                            mem_rden_d = 1'b1;
                            mem_be_d   = 4'b0000;
                            cnt_d      = 2'(RD_LAT - 1);
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = RD_CAP;
                end else begin
                    cnt_d      = cnt_q - 2'd1;
                    mem_rden_d = 1'b1;
                end
            end
            RD_CAP: begin
                case (f3_q)
                    3'b000:  rdata_d = {{24{lane_b[7]}}, lane_b};
                    3'b001:  rdata_d = {{16{lane_h[15]}}, lane_h};
                    3'b100:  rdata_d = {24'd0, lane_b};
                    3'b101:  rdata_d = {16'd0, lane_h};
                    default: rdata_d = bus.mem_q;
                endcase
                state_d = DONE;
                ready_d = 1'b1;
            end
            WR: begin
                state_d = DONE;
                ready_d = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            f3_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            mem_rden_q  <= 1'b0;
            mem_wren_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            f3_q        <= f3_d;
            lo_q        <= lo_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            mem_rden_q  <= mem_rden_d;
            mem_wren_q  <= mem_wren_d;
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.ready     = ready_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_rden  = mem_rden_q;
    assign bus.mem_wren  = mem_wren_q;
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the multicycle core's memory-request signals and the single-port word-wide data RAM, which has a registered read.
- Converts byte, halfword and word loads and stores (RV32I funct3 encodings) into word-addressed RAM accesses with byte enables.
- Sign- or zero-extends load data and returns it with a one-cycle ready pulse.
- Lets the core control unit wait on `ready` instead of hard-coding the RAM latency into its stage counter.

Parameters:
- ADDR_W, 10, word-address width driven to the RAM; uses byte address bits [ADDR_W+1:2].
- RD_LAT, 1, RAM read latency in cycles from rden to valid q; legal range 1..3.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  1  access request, sampled only in IDLE.
- we  input  1  1 = store, 0 = load; sampled with req.
- funct3  input  3  access size and sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; for stores 000 sb, 001 sh, 010 sw.
- addr  input  32  byte address; sampled with req.
- wdata  input  32  store data; low bits are used per size; sampled with req.
- rdata  output  32  extended load result; holds until the next load completes.
- ready  output  1  one-cycle completion pulse.
- busy  output  1  high from the cycle after req is accepted until ready.
- err  output  1  one-cycle pulse coincident with ready on an illegal access.
- mem_addr  output  ADDR_W  RAM word address.
- mem_wdata  output  32  lane-replicated store data.
- mem_be  output  4  byte enables.
- mem_rden  output  1  RAM read enable.
- mem_wren  output  1  RAM write enable.
- mem_q  input  32  RAM read data.

Behaviour:
- Reset:
  - rst_n low forces state IDLE.
  - All outputs go to 0, including rdata, mem_addr and mem_be.
  - Reset asserted mid-operation aborts the access; no ready pulse follows.
- States: IDLE, RD_WAIT, RD_CAP, WR, DONE.
- IDLE:
  - On req=1, register we, funct3, addr and wdata.
  - Illegal funct3 goes to DONE with err set. Illegal codes are loads 011/110/111 and stores other than 000/001/010.
  - Otherwise a load goes to RD_WAIT and a store goes to WR.
  - req=0 stays in IDLE.
- RD_WAIT:
  - mem_rden=1 and mem_addr=addr[ADDR_W+1:2] are driven for the full state.
  - A down-counter loaded with RD_LAT-1 decrements each cycle.
  - Go to RD_CAP when the counter reaches 0 (or immediately if RD_LAT=1).
- RD_CAP:
  - Sample mem_q.
  - Select the byte lane addr[1:0] or the halfword lane addr[1].
  - Extend: sign-extend for lb/lh, zero-extend for lbu/lhu, pass through for lw.
  - Register the result into rdata and go to DONE.
- WR:
  - mem_wren=1 for exactly one cycle.
  - sb: mem_be = 4'b0001 << addr[1:0]; mem_wdata = byte replicated ×4.
  - sh: mem_be = addr[1] ? 1100 : 0011; mem_wdata = halfword replicated ×2.
  - sw: mem_be = 1111; mem_wdata = wdata.
  - Then go to DONE.
- DONE: ready=1 for one cycle, plus err if flagged; return to IDLE.
- Latency from the req-accept edge to ready high:
  - Load: RD_LAT+2 cycles.
  - Store: 2 cycles.
  - Illegal access: 1 cycle.
- busy is high in every state except IDLE.
- A req arriving while busy is ignored, with no queueing.
- req held high through DONE re-triggers a new access on the first IDLE cycle.
- mem_rden and mem_wren are never high together. Both are 0 in IDLE, RD_CAP and DONE.
- rdata is unchanged by stores and by illegal accesses.
- Address arithmetic: mem_addr wraps modulo 2^ADDR_W; upper addr bits are ignored.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A halfword access with addr[0]=1, or a word access with addr[1:0]≠00, is illegal.
  - The unit goes to DONE with err set and makes no RAM access.
- Not defined:
  - Misaligned low bits are forced to alignment: addr[0] cleared for halfwords, addr[1:0] cleared for words.
  - The access proceeds normally and err never fires for alignment.

Test Plan:
- Reset: rst_n=0 during RD_WAIT, then release → state IDLE, ready/busy/err/mem_rden=0, rdata=0, no ready pulse.
- Byte load: RAM word 0x80 holds 0x11F2_3344; req lb at addr 0x82, RD_LAT=1 → mem_rden with mem_addr=0x20; ready after 3 cycles; rdata=0xFFFF_FFF2. The same access as lbu → rdata=0x0000_00F2.
- Stores:
  - sh wdata=0x0000_ABCD at addr 0x106 → one-cycle mem_wren, mem_be=1100, mem_wdata=0xABCD_ABCD, ready 2 cycles after accept.
  - sb wdata=0x5A at addr 0x03 → mem_be=1000.
- Busy and back-to-back: second req during RD_WAIT is ignored; req held through DONE → new access starts on the next IDLE cycle; RD_LAT=3 → ready 5 cycles after accept.
- Illegal funct3: load funct3=011 → ready and err together 1 cycle after accept, no mem_rden, rdata unchanged.
- Misalignment: lw at addr 0x41
  - With MISALIGN_TRAP_EN → err=1, no RAM access.
  - Without → mem_addr=0x10, full-word result, err=0.
